// File: rtl/fp_mul_round_pack.sv
// Normalize/round/pack stage for the binary32 multiplier: two registered stages
// (S1 normalize + denormal shift, S2 round + pack) with valid/ready on both sides.
module fp_mul_round_pack #(
  parameter int EXP_W     = 10,
  parameter int SHIFT_CAP = 26
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [47:0]      in_mant,
  input  logic [1:0]       in_class,
  input  logic [2:0]       in_frm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      result,
  output logic             overflow,
  output logic             underflow,
  output logic             inexact
);

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'b00,
    CLS_ZERO   = 2'b01,
    CLS_INF    = 2'b10,
    CLS_NAN    = 2'b11
  } cls_t;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_t;

  localparam int EW = EXP_W + 1;
  localparam int SW = $clog2(SHIFT_CAP + 1);
  localparam int XW = 25 + SHIFT_CAP;

  logic          s1_valid, s2_valid, s2_can_load;
  logic          s1_sign, s1_g, s1_s, s1_tiny;
  logic [EW-1:0] s1_exp;
  logic [23:0]   s1_sig;
  cls_t          s1_cls;
  rm_t           s1_rm;

  assign s2_can_load = !s2_valid || out_ready;
  assign in_ready    = !s1_valid || s2_can_load;
  assign out_valid   = s2_valid;

  // S1: normalize, then right-shift tiny results into the denormal range
  logic [EW-1:0] n_exp, sh_full;
  logic [SW-1:0] sh;
  logic [XW-1:0] ext;
  logic [23:0]   n_sig;
  logic          n_g, n_s, n_tiny;
  rm_t           n_rm;

  always_comb begin
    n_exp = {in_exp[EXP_W-1], in_exp} + EW'(in_mant[47]);
    if (in_mant[47]) begin
      n_sig = in_mant[47:24];
      n_g   = in_mant[23];
      n_s   = |in_mant[22:0];
    end else begin
      n_sig = in_mant[46:23];
      n_g   = in_mant[22];
      n_s   = |in_mant[21:0];
    end
    n_tiny  = n_exp[EW-1] || (n_exp == '0);
    sh_full = EW'(1) - n_exp;
    sh      = (sh_full > EW'(SHIFT_CAP)) ? SW'(SHIFT_CAP) : sh_full[SW-1:0];
    ext     = {n_sig, n_g, {SHIFT_CAP{1'b0}}} >> sh;
    if (n_tiny) begin
      n_sig = ext[XW-1 -: 24];
      n_g   = ext[SHIFT_CAP];
      n_s   = n_s | (|ext[SHIFT_CAP-1:0]);
      n_exp = '0;
    end
    n_rm = (in_frm > 3'd4) ? RM_RNE : rm_t'(in_frm);
  end

  // S2: round, renormalize on carry, detect overflow, pack
  logic          inc, to_inf, gs;
  logic [24:0]   sum;
  logic [23:0]   r_sig;
  logic [EW-1:0] r_exp;
  logic [31:0]   r_res;
  logic          r_ovf, r_unf, r_inx;

  always_comb begin
    gs     = s1_g | s1_s;
    inc    = 1'b0;
    to_inf = 1'b1;
    case (s1_rm)
      RM_RNE: inc = s1_g & (s1_s | s1_sig[0]);
      RM_RTZ: begin inc = 1'b0;            to_inf = 1'b0;     end
      RM_RDN: begin inc = gs & s1_sign;    to_inf = s1_sign;  end
      RM_RUP: begin inc = gs & !s1_sign;   to_inf = !s1_sign; end
      RM_RMM: inc = s1_g;
      default: inc = 1'b0;
    endcase
    sum   = {1'b0, s1_sig} + 25'(inc);
    r_sig = sum[24] ? sum[24:1] : sum[23:0];
    // A denormal that rounds up into the hidden bit becomes the smallest normal
    r_exp = s1_exp + EW'(sum[24]) + EW'(s1_tiny & r_sig[23]);
    r_ovf = r_exp >= EW'(255);
    r_unf = s1_tiny & gs;
    r_inx = gs | r_ovf;
    if (r_ovf)
      r_res = to_inf ? {s1_sign, 8'hFF, 23'h0} : {s1_sign, 31'h7F7F_FFFF};
    else
      r_res = {s1_sign, r_exp[7:0], r_sig[22:0]};
    case (s1_cls)
      CLS_ZERO: begin r_res = {s1_sign, 31'h0};        r_ovf = 1'b0; r_unf = 1'b0; r_inx = 1'b0; end
      CLS_INF:  begin r_res = {s1_sign, 8'hFF, 23'h0}; r_ovf = 1'b0; r_unf = 1'b0; r_inx = 1'b0; end
      CLS_NAN:  begin r_res = 32'h7FC0_0000;           r_ovf = 1'b0; r_unf = 1'b0; r_inx = 1'b0; end
      default:  ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_exp    <= '0;
      s1_sig    <= '0;
      s1_g      <= 1'b0;
      s1_s      <= 1'b0;
      s1_tiny   <= 1'b0;
      s1_cls    <= CLS_NORMAL;
      s1_rm     <= RM_RNE;
      s2_valid  <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
    end else begin
      if (s2_can_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          result    <= r_res;
          overflow  <= r_ovf;
          underflow <= r_unf;
          inexact   <= r_inx;
        end
      end
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sign <= in_sign;
          s1_exp  <= n_exp;
          s1_sig  <= n_sig;
          s1_g    <= n_g;
          s1_s    <= n_s;
          s1_tiny <= n_tiny;
          s1_cls  <= cls_t'(in_class);
          s1_rm   <= n_rm;
        end
      end
    end
  end

endmodule
